// File: rtl/riscv_multicycle_core.sv
// Multi-cycle RV32I/RV32E integer core: FETCH/DECODE/EXEC/WB with a sticky trap.
// Covers register-register, register-immediate and LUI; everything else halts.
module riscv_multicycle_core #(
    parameter int          NUM_REGS = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_valid_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] pc_o,
    output logic        retire_o,
    output logic        illegal_o,
    input  logic [4:0]  dbg_addr_i,
    output logic [31:0] dbg_data_o
);

    localparam int AW = (NUM_REGS == 16) ? 4 : 5;
    localparam logic [5:0] W_NREGS = 6'(NUM_REGS);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_TRAP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_y;
    logic [31:0] r_rf [NUM_REGS];

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [2:0]  w_f3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [6:0]  w_f7;
    logic        w_is_r;
    logic        w_is_i;
    logic        w_is_lui;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_u;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;
    logic        w_legal;
    logic        w_use_rs1;
    logic        w_use_rs2;
    logic        w_sub;
    logic [31:0] w_sra;
    logic [31:0] w_alu;
    logic        w_req;
    logic        w_retire;
    logic        w_trap;

    assign w_opcode = r_ir[6:0];
    assign w_rd     = r_ir[11:7];
    assign w_f3     = r_ir[14:12];
    assign w_rs1    = r_ir[19:15];
    assign w_rs2    = r_ir[24:20];
    assign w_f7     = r_ir[31:25];
    assign w_is_r   = (w_opcode == 7'b0110011);
    assign w_is_i   = (w_opcode == 7'b0010011);
    assign w_is_lui = (w_opcode == 7'b0110111);
    assign w_imm_i  = {{20{r_ir[31]}}, r_ir[31:20]};
    assign w_imm_u  = {r_ir[31:12], 12'b0};

    // x0 and indices beyond the implemented file read as zero
    always_comb begin
        w_rs1_val = '0;
        if (w_rs1 != 5'd0 && {1'b0, w_rs1} < W_NREGS)
            w_rs1_val = r_rf[w_rs1[AW-1:0]];
    end

    always_comb begin
        w_rs2_val = '0;
        if (w_rs2 != 5'd0 && {1'b0, w_rs2} < W_NREGS)
            w_rs2_val = r_rf[w_rs2[AW-1:0]];
    end

    always_comb begin
        dbg_data_o = '0;
        if (dbg_addr_i != 5'd0 && {1'b0, dbg_addr_i} < W_NREGS)
            dbg_data_o = r_rf[dbg_addr_i[AW-1:0]];
    end

    always_comb begin
        w_legal   = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        unique case (1'b1)
            w_is_r: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_legal   = (w_f7 == 7'b0000000) ||
                            (w_f7 == 7'b0100000 &&
                             (w_f3 == 3'b000 || w_f3 == 3'b101));
            end
            w_is_i: begin
                w_use_rs1 = 1'b1;
                if (w_f3 == 3'b001)
                    w_legal = (w_f7 == 7'b0000000);
                else if (w_f3 == 3'b101)
                    w_legal = (w_f7 == 7'b0000000) ||
                              (w_f7 == 7'b0100000);
                else
                    w_legal = 1'b1;
            end
            w_is_lui: w_legal = 1'b1;
            default:  w_legal = 1'b0;
        endcase
        // RV32E: any used register field reaching x16..x31 is illegal
        if (NUM_REGS == 16 &&
            (w_rd[4] || (w_use_rs1 && w_rs1[4]) ||
             (w_use_rs2 && w_rs2[4])))
            w_legal = 1'b0;
    end

    assign w_sub = w_is_r & w_f7[5];
    assign w_sra = $signed(r_a) >>> r_b[4:0];

    always_comb begin
        w_alu = '0;
        if (w_is_lui)
            w_alu = r_b;
        else
            unique case (w_f3)
                3'b000: w_alu = w_sub ? r_a - r_b : r_a + r_b;
                3'b001: w_alu = r_a << r_b[4:0];
                3'b010: w_alu = {31'b0, $signed(r_a) < $signed(r_b)};
                3'b011: w_alu = {31'b0, r_a < r_b};
                3'b100: w_alu = r_a ^ r_b;
                3'b101: w_alu = w_f7[5] ? w_sra : r_a >> r_b[4:0];
                3'b110: w_alu = r_a | r_b;
                3'b111: w_alu = r_a & r_b;
            endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_retire    = 1'b0;
        w_trap      = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_req = 1'b1;
                if (imem_valid_i)
                    w_state_nxt = S_DECODE;
            end
            S_DECODE: w_state_nxt = w_legal ? S_EXEC : S_TRAP;
            S_EXEC:   w_state_nxt = S_WB;
            S_WB: begin
                w_retire    = 1'b1;
                w_state_nxt = S_FETCH;
            end
            S_TRAP:   w_trap = 1'b1;
            default:  w_state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_state <= S_FETCH;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc <= RESET_PC;
            r_ir <= '0;
            r_a  <= '0;
            r_b  <= '0;
            r_y  <= '0;
            for (int i = 0; i < NUM_REGS; i++)
                r_rf[i] <= '0;
        end else begin
            case (r_state)
                S_FETCH:
                    if (imem_valid_i)
                        r_ir <= imem_data_i;
                S_DECODE: begin
                    r_a <= w_rs1_val;
                    if (w_is_lui)
                        r_b <= w_imm_u;
                    else if (w_is_i)
                        r_b <= w_imm_i;
                    else
                        r_b <= w_rs2_val;
                end
                S_EXEC: r_y <= w_alu;
                S_WB: begin
                    if (w_rd != 5'd0)
                        r_rf[w_rd[AW-1:0]] <= r_y;
                    r_pc <= r_pc + 32'd4;
                end
                default: ;
            endcase
        end
    end

    // handshake outputs are forced low while reset is asserted
    assign imem_req_o  = w_req & ~rst_i;
    assign retire_o    = w_retire & ~rst_i;
    assign illegal_o   = w_trap & ~rst_i;
    assign imem_addr_o = r_pc;
    assign pc_o        = r_pc;

endmodule

// File: tb/tb_riscv_multicycle_core.sv
// Bench for riscv_multicycle_core: RV32I and RV32E instances driven
// with directed and random instruction streams against an ISA-level model.
module tb_riscv_multicycle_core;

    logic        clk = 1'b0;
    logic        rst      [2];
    logic        valid    [2];
    logic [31:0] data     [2];
    logic [4:0]  dbg_addr [2];
    logic        req      [2];
    logic        retire   [2];
    logic        illegal  [2];
    logic [31:0] addr     [2];
    logic [31:0] pc       [2];
    logic [31:0] dbg_data [2];

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mregs [2][32];
    logic [31:0] mpc   [2];

    always #50 clk = ~clk;

    riscv_multicycle_core #(
        .NUM_REGS(32),
        .RESET_PC(32'h0000_0000)
    ) u_dut32 (
        .clk_i(clk),
        .rst_i(rst[0]),
        .imem_req_o(req[0]),
        .imem_addr_o(addr[0]),
        .imem_valid_i(valid[0]),
        .imem_data_i(data[0]),
        .pc_o(pc[0]),
        .retire_o(retire[0]),
        .illegal_o(illegal[0]),
        .dbg_addr_i(dbg_addr[0]),
        .dbg_data_o(dbg_data[0])
    );

    riscv_multicycle_core #(
        .NUM_REGS(16),
        .RESET_PC(32'hFFFF_FFF8)
    ) u_dut16 (
        .clk_i(clk),
        .rst_i(rst[1]),
        .imem_req_o(req[1]),
        .imem_addr_o(addr[1]),
        .imem_valid_i(valid[1]),
        .imem_data_i(data[1]),
        .pc_o(pc[1]),
        .retire_o(retire[1]),
        .illegal_o(illegal[1]),
        .dbg_addr_i(dbg_addr[1]),
        .dbg_data_o(dbg_data[1])
    );

    function automatic int nr(input int u);
        return (u == 0) ? 32 : 16;
    endfunction

    function automatic logic [31:0] rpc(input int u);
        return (u == 0) ? 32'h0000_0000 : 32'hFFFF_FFF8;
    endfunction

    function automatic logic [31:0] enc_r(
        input logic [6:0] f7, input logic [4:0] rs2,
        input logic [4:0] rs1, input logic [2:0] f3,
        input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(
        input logic [11:0] imm, input logic [4:0] rs1,
        input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'h13};
    endfunction

    function automatic logic [31:0] enc_u(
        input logic [19:0] imm, input logic [4:0] rd);
        return {imm, rd, 7'h37};
    endfunction

    // ISA legality: which encodings exist and which registers they name
    function automatic bit ref_legal(input logic [31:0] w, input int nregs);
        bit ok;
        bit u1;
        bit u2;
        ok = 0;
        u1 = 0;
        u2 = 0;
        if (w[6:0] == 7'h33) begin
            u1 = 1;
            u2 = 1;
            ok = (w[31:25] == 7'h00) ||
                 (w[31:25] == 7'h20 && (w[14:12] == 3'd0 || w[14:12] == 3'd5));
        end else if (w[6:0] == 7'h13) begin
            u1 = 1;
            if (w[14:12] == 3'd1)
                ok = (w[31:25] == 7'h00);
            else if (w[14:12] == 3'd5)
                ok = (w[31:25] == 7'h00) || (w[31:25] == 7'h20);
            else
                ok = 1;
        end else if (w[6:0] == 7'h37) begin
            ok = 1;
        end
        if (ok && nregs == 16) begin
            if (w[11:7] >= 16) ok = 0;
            if (u1 && w[19:15] >= 16) ok = 0;
            if (u2 && w[24:20] >= 16) ok = 0;
        end
        return ok;
    endfunction

    function automatic logic [31:0] ref_result(input int u, input logic [31:0] w);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sra_v;
        if (w[6:0] == 7'h37)
            return {w[31:12], 12'h000};
        a = mregs[u][w[19:15]];
        if (w[6:0] == 7'h33)
            b = mregs[u][w[24:20]];
        else
            b = {{20{w[31]}}, w[31:20]};
        sra_v = $signed(a) >>> b[4:0];
        case (w[14:12])
            3'd0: return (w[6:0] == 7'h33 && w[30]) ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return w[30] ? sra_v : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic [31:0] gen(input int nregs);
        int k;
        int j;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [11:0] imm;
        k   = int'($urandom_range(0, 19));
        rd  = 5'($urandom_range(0, nregs - 1));
        rs1 = 5'($urandom_range(0, nregs - 1));
        rs2 = 5'($urandom_range(0, nregs - 1));
        imm = 12'($urandom);
        if (k < 8) return enc_r(7'h00, rs2, rs1, 3'(k), rd);
        if (k == 8) return enc_r(7'h20, rs2, rs1, 3'd0, rd);
        if (k == 9) return enc_r(7'h20, rs2, rs1, 3'd5, rd);
        if (k < 18) begin
            j = k - 10;
            if (j == 1 || j == 5) imm = {7'h00, imm[4:0]};
            return enc_i(imm, rs1, 3'(j), rd);
        end
        if (k == 18) return enc_i({7'h20, imm[4:0]}, rs1, 3'd5, rd);
        return enc_u(20'($urandom), rd);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input int u, input int idx,
                           input logic [31:0] exp, input string tag);
        dbg_addr[u] = 5'(idx);
        #1;
        chk(tag, dbg_data[u], exp);
    endtask

    task automatic check_regs(input int u, input string tag);
        for (int i = 0; i < 32; i++) begin
            dbg_addr[u] = 5'(i);
            #1;
            chk($sformatf("%s_u%0d_x%0d", tag, u, i), dbg_data[u],
                (i == 0 || i >= nr(u)) ? 32'h0 : mregs[u][i]);
        end
    endtask

    task automatic model_reset(input int u);
        mpc[u] = rpc(u);
        for (int i = 0; i < 32; i++)
            mregs[u][i] = '0;
    endtask

    task automatic do_reset(input int u);
        rst[u]   = 1'b1;
        valid[u] = 1'b1;
        data[u]  = $urandom;
        tick();
        chk("rst1_req", 32'(req[u]), 0);
        chk("rst1_retire", 32'(retire[u]), 0);
        chk("rst1_illegal", 32'(illegal[u]), 0);
        tick();
        chk("rst2_req", 32'(req[u]), 0);
        chk("rst2_illegal", 32'(illegal[u]), 0);
        chk("rst2_pc", pc[u], rpc(u));
        rst[u] = 1'b0;
        model_reset(u);
        #1;
        chk("rel_req", 32'(req[u]), 1);
        chk("rel_addr", addr[u], rpc(u));
        chk("rel_pc", pc[u], rpc(u));
        chk("rel_illegal", 32'(illegal[u]), 0);
        check_regs(u, "rst");
        valid[u] = 1'b0;
    endtask

    // entered during a FETCH cycle; returns in the next FETCH cycle or TRAP
    task automatic run_instr(input int u, input logic [31:0] w,
                             input int stalls);
        bit legal;
        logic [31:0] res;
        legal = ref_legal(w, nr(u));
        for (int s = 0; s < stalls; s++) begin
            valid[u] = 1'b0;
            data[u]  = $urandom;
            #1;
            chk("stall_req", 32'(req[u]), 1);
            chk("stall_addr", addr[u], mpc[u]);
            chk("stall_retire", 32'(retire[u]), 0);
            tick();
        end
        valid[u] = 1'b1;
        data[u]  = w;
        #1;
        chk("fetch_req", 32'(req[u]), 1);
        chk("fetch_addr", addr[u], mpc[u]);
        chk("fetch_retire", 32'(retire[u]), 0);
        tick();
        valid[u] = 1'($urandom_range(0, 1));
        data[u]  = $urandom;
        #1;
        chk("dec_req", 32'(req[u]), 0);
        chk("dec_retire", 32'(retire[u]), 0);
        chk("dec_illegal", 32'(illegal[u]), 0);
        tick();
        if (legal) begin
            valid[u] = 1'($urandom_range(0, 1));
            #1;
            chk("exe_req", 32'(req[u]), 0);
            chk("exe_retire", 32'(retire[u]), 0);
            tick();
            #1;
            chk("wb_retire", 32'(retire[u]), 1);
            chk("wb_req", 32'(req[u]), 0);
            res = ref_result(u, w);
            if (w[11:7] != 5'd0)
                mregs[u][w[11:7]] = res;
            mpc[u] = mpc[u] + 32'd4;
            tick();
            dbg_addr[u] = w[11:7];
            #1;
            chk($sformatf("wr_x%0d_%h", w[11:7], w), dbg_data[u],
                (w[11:7] == 5'd0) ? 32'h0 : mregs[u][w[11:7]]);
            chk("next_pc", pc[u], mpc[u]);
            valid[u] = 1'b0;
        end else begin
            for (int k = 0; k < 6; k++) begin
                valid[u] = 1'($urandom_range(0, 1));
                data[u]  = $urandom;
                #1;
                chk("trap_illegal", 32'(illegal[u]), 1);
                chk("trap_req", 32'(req[u]), 0);
                chk("trap_retire", 32'(retire[u]), 0);
                chk("trap_pc", pc[u], mpc[u]);
                tick();
            end
            check_regs(u, "trap");
        end
    endtask

    logic [31:0] bad [5];

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst[u]      = 1'b1;
            valid[u]    = 1'b0;
            data[u]     = '0;
            dbg_addr[u] = '0;
        end

        do_reset(0);
        run_instr(0, enc_i(12'd5, 5'd0, 3'd0, 5'd1), 0);
        run_instr(0, enc_i(12'hFFD, 5'd0, 3'd0, 5'd2), 0);
        run_instr(0, enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 0);
        run_instr(0, enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd4), 0);
        run_instr(0, enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd5), 0);
        run_instr(0, enc_r(7'h20, 5'd1, 5'd2, 3'd5, 5'd6), 0);
        chk_reg(0, 3, 32'h0000_0002, "seq_x3");
        chk_reg(0, 4, 32'hFFFF_FFF8, "seq_x4");
        chk_reg(0, 5, 32'h0000_0001, "seq_x5");
        chk_reg(0, 6, 32'hFFFF_FFFF, "seq_x6");
        chk("seq_pc", pc[0], 32'd24);

        run_instr(0, enc_i(12'd7, 5'd0, 3'd0, 5'd0), 0);
        run_instr(0, enc_u(20'hABCDE, 5'd7), 0);
        chk_reg(0, 0, 32'h0, "x0_zero");
        chk_reg(0, 7, 32'hABCD_E000, "lui_x7");

        run_instr(0, enc_i(12'h123, 5'd1, 3'd0, 5'd8), 5);

        for (int n = 0; n < 80; n++)
            run_instr(0, gen(32), int'($urandom_range(0, 2)));
        check_regs(0, "rand");

        // reset while ADDI x1,x0,9 sits in EXEC
        do_reset(0);
        run_instr(0, enc_i(12'd1, 5'd0, 3'd0, 5'd2), 0);
        valid[0] = 1'b1;
        data[0]  = enc_i(12'd9, 5'd0, 3'd0, 5'd1);
        tick();
        valid[0] = 1'b0;
        tick();
        rst[0] = 1'b1;
        #1;
        chk("mid_retire_exec", 32'(retire[0]), 0);
        tick();
        rst[0] = 1'b0;
        model_reset(0);
        #1;
        chk("mid_retire", 32'(retire[0]), 0);
        chk("mid_req", 32'(req[0]), 1);
        chk("mid_pc", pc[0], 32'h0);
        chk_reg(0, 1, 32'h0, "mid_x1");
        chk_reg(0, 2, 32'h0, "mid_x2");
        run_instr(0, enc_i(12'd3, 5'd0, 3'd0, 5'd1), 1);
        run_instr(0, enc_i(12'd4, 5'd0, 3'd0, 5'd2), 0);
        chk("pre_trap_pc", pc[0], 32'd8);
        run_instr(0, 32'h0000_0000, 0);
        chk("trap_pc8", pc[0], 32'd8);
        chk("trap_sticky", 32'(illegal[0]), 1);

        bad[0] = enc_r(7'h20, 5'd2, 5'd1, 3'd4, 5'd3);
        bad[1] = enc_i({7'h20, 5'd3}, 5'd1, 3'd1, 5'd3);
        bad[2] = enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd3);
        bad[3] = 32'h0000_2083;
        bad[4] = enc_i({7'h40, 5'd1}, 5'd1, 3'd5, 5'd3);
        for (int b = 0; b < 5; b++) begin
            do_reset(0);
            run_instr(0, enc_i(12'h055, 5'd0, 3'd0, 5'd5), 0);
            run_instr(0, bad[b], int'($urandom_range(0, 1)));
        end

        do_reset(1);
        run_instr(1, enc_i(12'd1, 5'd0, 3'd0, 5'd3), 0);
        run_instr(1, enc_i(12'd2, 5'd3, 3'd0, 5'd15), 0);
        run_instr(1, enc_u(20'h12345, 5'd4), 0);
        chk("e_wrap_pc", pc[1], 32'd4);
        chk_reg(1, 15, 32'd3, "e_x15");
        chk_reg(1, 20, 32'h0, "e_dbg_x20");
        for (int n = 0; n < 20; n++)
            run_instr(1, gen(16), int'($urandom_range(0, 2)));
        check_regs(1, "e_rand");
        run_instr(1, enc_i(12'd1, 5'd0, 3'd0, 5'd17), 0);
        chk("e_x17_trap", 32'(illegal[1]), 1);
        do_reset(1);
        run_instr(1, enc_r(7'h00, 5'd20, 5'd2, 3'd0, 5'd1), 0);
        chk("e_rs2_trap", 32'(illegal[1]), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_multicycle_core.md
# riscv_multicycle_core

Parametrised multi-cycle RV32I integer core, the successor to the single-cycle datapath top. It fetches instructions over a valid-based instruction-memory port and executes each one through a FETCH/DECODE/EXEC/WB state machine. The integer register-register and register-immediate subset plus LUI is implemented. The register file depth is selectable, so RV32E uses 16 registers. Unsupported encodings trap and the core halts. It sits between the instruction memory and the future load/store and branch units.

## Interface
- NUM_REGS, 32: architectural registers; legal values 32 (RV32I) and 16 (RV32E).
- RESET_PC, 32'h0000_0000: PC loaded on reset; must be 4-byte aligned.
- clk_i  in  1  core clock; all state changes on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- imem_req_o  out  1  fetch request; high only in FETCH.
- imem_addr_o  out  32  fetch address; equals pc_o.
- imem_valid_i  in  1  instruction valid; sampled only while imem_req_o=1.
- imem_data_i  in  32  instruction word; captured when imem_req_o & imem_valid_i.
- pc_o  out  32  current PC.
- retire_o  out  1  one-cycle pulse in the WB cycle of each retired instruction.
- illegal_o  out  1  sticky; high while in TRAP.
- dbg_addr_i  in  5  debug register index.
- dbg_data_o  out  32  combinational read of register dbg_addr_i; reads 0 for x0 and for indices >= NUM_REGS.

## Operation
- States: FETCH, DECODE, EXEC, WB, TRAP.
- Reset effect: state=FETCH, pc=RESET_PC, all registers=0, IR=0, retire_o=0, illegal_o=0, imem_req_o=0 during the reset cycle.
- FETCH: imem_req_o=1, imem_addr_o=pc. The core waits indefinitely until imem_valid_i=1, then latches IR and moves to DECODE.
- DECODE: reads rs1/rs2 into operand registers A/B, builds the immediate, and checks legality. Illegal -> TRAP; legal -> EXEC.
- Legal R-type (opcode 0110011): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND. funct7 must be 0000000, or 0100000 only for SUB and SRA.
- Legal I-type (opcode 0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI. imm[11:5] for shifts must be 0000000, or 0100000 only for SRAI.
- Legal U-type: LUI (opcode 0110111).
- Everything else is illegal, including IR=32'h0.
- NUM_REGS=16: any of rd/rs1/rs2 bit 4 set (for fields the format uses) -> illegal.
- EXEC: computes the result into register Y.
  - Arithmetic is modulo 2^32.
  - Shift amount is B[4:0] or imm[4:0].
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned with the sign-extended immediate.
  - LUI: Y = {imm[31:12], 12'b0}.
- WB: writes Y to rd unless rd=0, so x0 stays 0. Then pc <= pc+4 (wraps 32'hFFFF_FFFC -> 0), retire_o=1, and the state returns to FETCH.
- TRAP: pc_o holds the faulting instruction's PC, illegal_o=1, imem_req_o=0, and no register writes occur. The core stays in TRAP until rst_i.
- rst_i has priority in every state. An in-flight instruction is discarded with no write and no retire.

## Timing
- Minimum 4 cycles per instruction, reached when imem_valid_i is high in the first FETCH cycle. Each FETCH stall cycle adds 1.
- A register written in WB is visible to the next instruction's DECODE. No forwarding is needed.
- dbg_data_o reflects a WB write starting the cycle after the write edge.
- Trap entry: illegal_o rises the cycle after DECODE, i.e. the cycle TRAP is entered. retire_o does not pulse for the trapping instruction.
- If imem_valid_i is high while imem_req_o=0, it is ignored.

## Test plan
- Reset/fetch: hold rst_i 2 cycles, then release with imem_valid_i=1 -> imem_req_o=1 and imem_addr_o=RESET_PC in the first cycle; pc_o=0 and illegal_o=0.
- ALU sequence: ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SUB x4,x2,x1; SLTU x5,x1,x2; SRA x6,x2,x1 -> x3=2, x4=0xFFFF_FFF8, x5=1, x6=0xFFFF_FFFF. retire_o pulses every 4 cycles; pc_o=24 after the sequence.
- x0 and LUI: ADDI x0,x0,7 then LUI x7,0xABCDE -> x0=0, x7=0xABCD_E000.
- Fetch stall: imem_valid_i held low for 5 cycles -> imem_req_o and imem_addr_o stay stable, no retire, and the instruction completes 9 cycles after FETCH entry.
- Illegal: word 32'h0000_0000 at PC 8 -> illegal_o=1 from the cycle after DECODE. pc_o stays 8, imem_req_o=0, registers unchanged, and the core stays stopped until rst_i. With NUM_REGS=16, ADDI x17,x0,1 also traps.
- Reset mid-instruction: assert rst_i during EXEC of ADDI x1,x0,9 -> x1 stays 0, no retire_o, and the core restarts fetch at RESET_PC.
